rep_ctrl: RTL and testbench
===========================

REP_CTRL -- requirements
Module: rep_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset: ports clk and clr.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 clr  input  1  asynchronous active-high reset.
REQ-004 valid_in  input  1  instruction present in the register-read/address-generation stage.
REQ-005 is_rep_in  input  1  instruction carries a REP prefix.
REQ-006 rep_num  input  32  iteration count (ECX) from the address-generation stage; 0 when not REP.
REQ-007 opsize_in  input  2  element size code: 00=1B, 01=2B, 10=4B, 11=8B.
REQ-008 df  input  1  direction flag; 1 means decrementing addresses.
REQ-009 stall_in  input  1  downstream/forwarding stall; no issue is allowed while it is high.
REQ-010 flush  input  1  pipeline flush (branch mispredict or exception).
REQ-011 issue_valid  output  1  one element operation issued this cycle.
REQ-012 iter_last  output  1  the issued operation is the final iteration.
REQ-013 zero_rep  output  1  one-cycle pulse when a REP instruction with count 0 is retired as a no-op.
REQ-014 hold  output  1  upstream hold: the stage input latch SHALL NOT advance while high.
REQ-015 offs  output  32  byte offset added to mem_addr1/mem_addr2 for the current iteration.
REQ-016 remaining  output  32  iterations not yet issued, including the current one.
REQ-017 busy  output  1  high while the state is RUN.

Function
REQ-018 States: IDLE and RUN, with a 1-bit encoding (IDLE=0).
REQ-019 IDLE, valid_in=1 and is_rep_in=0:
- issue_valid = !stall_in (combinational).
- iter_last = issue_valid.
- hold = 0, offs = 0, no state change.
REQ-020 IDLE, valid_in=1, is_rep_in=1, rep_num=0:
- zero_rep = 1 and issue_valid = 0.
- hold = 0; the state stays IDLE.
REQ-021 IDLE, valid_in=1, is_rep_in=1, rep_num!=0:
- hold = 1 and issue_valid = 0.
- On the edge: cnt<=rep_num, offs<=0, step latched from opsize_in/df, state<=RUN.
- stall_in does not block this load.
REQ-022 RUN: issue_valid = !stall_in and iter_last = issue_valid & (cnt==1).
REQ-023 RUN: hold = !(issue_valid & iter_last), so the latch advances in the same cycle the last iteration issues.
REQ-024 RUN, on each issue edge:
- cnt<=cnt-1.
- offs<=offs+step modulo 2^32, where step = +(1<<opsize) for df=0 and -(1<<opsize) for df=1 (two's complement).
REQ-025 RUN, issue with cnt==1: next state is IDLE, cnt<=0, offs<=0.
REQ-026 RUN with stall_in=1: cnt, offs and the state SHALL hold and hold=1.
REQ-027 Step and direction SHALL be latched at the RUN entry; opsize_in and df changes during RUN are ignored.
REQ-028 flush=1 in any state:
- issue_valid=0, zero_rep=0, hold=0.
- Next state IDLE, cnt<=0, offs<=0.
- flush overrides a simultaneous last issue or load.
REQ-029 remaining = cnt in RUN and 0 in IDLE; busy = (state==RUN).
REQ-030 rep_num=0xFFFFFFFF SHALL be accepted. cnt SHALL never wrap below 0, and offs wraps silently.
REQ-031 Latency: a non-REP instruction issues in 0 added cycles. An N-iteration REP occupies N+1 stall-free cycles: one load cycle plus N issue cycles.

Reset
REQ-032 While clr is asserted: state=IDLE, cnt=0, offs=0, and therefore busy=0 and remaining=0.
REQ-033 issue_valid, iter_last, zero_rep and hold SHALL follow their IDLE equations with the latched state reset.
REQ-034 clr asserted mid-RUN SHALL abort the sequence immediately, with no further issues after release until a new load.

Structure
REQ-035 The state encoding, the opsize-to-step constants (1/2/4/8) and the 32-bit data width SHALL live in the shared processor definitions package/header.
REQ-036 One sub-module, rep_offs_acc, SHALL hold offs and compute offs+step with the existing kogeAdder; rep_ctrl contains the FSM and counter.

Verification
REQ-037 Non-REP: valid_in=1, is_rep_in=0, stall_in=0 -> issue_valid=1, iter_last=1, hold=0, offs=0 in the same cycle.
REQ-038 REP, rep_num=3, opsize=10, df=0, no stall:
- Load cycle with hold=1.
- Then 3 issues with offs=0,4,8 and remaining=3,2,1.
- iter_last only on the 3rd issue; hold=0 on that cycle; busy drops after it.
REQ-039 REP, rep_num=2, opsize=00, df=1, stall_in high for 2 cycles between the issues:
- offs=0 then 0xFFFFFFFF.
- No issue and no counter change during the stall.
REQ-040 REP, rep_num=0 -> zero_rep pulse for 1 cycle, no issue_valid, hold=0, state stays IDLE.
REQ-041 REP, rep_num=5, flush at the 2nd issue cycle -> no issue that cycle, IDLE next cycle, remaining=0, offs=0.
REQ-042 clr asserted asynchronously mid-RUN with rep_num=4 -> busy=0 and remaining=0 immediately; no issue after release.

Source files
------------

// File: rtl/rep_ctrl_pkg.sv
// Shared definitions for the REP string-instruction sequencer.
package rep_ctrl_pkg;

  localparam int unsigned DATA_W = 32;

  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam data_t STEP_1B = data_t'(1);
  localparam data_t STEP_2B = data_t'(2);
  localparam data_t STEP_4B = data_t'(4);
  localparam data_t STEP_8B = data_t'(8);

  // Signed per-iteration address step: element size, negated when df is set.
  function automatic data_t step_of(input logic [1:0] opsize, input logic dir);
    data_t mag;
    case (opsize)
      2'b00:   mag = STEP_1B;
      2'b01:   mag = STEP_2B;
      2'b10:   mag = STEP_4B;
      default: mag = STEP_8B;
    endcase
    return dir ? ((~mag) + data_t'(1)) : mag;
  endfunction

endpackage

// File: rtl/rep_ctrl_if.sv
// Pipeline-side bus of the REP sequencer: stage inputs and issue outputs.
interface rep_ctrl_if;
  import rep_ctrl_pkg::*;

  logic       valid_in;
  logic       is_rep_in;
  data_t      rep_num;
  logic [1:0] opsize_in;
  logic       df;
  logic       stall_in;
  logic       flush;

  logic       issue_valid;
  logic       iter_last;
  logic       zero_rep;
  logic       hold;
  data_t      offs;
  data_t      remaining;
  logic       busy;

  modport master (
    output valid_in, is_rep_in, rep_num, opsize_in, df, stall_in, flush,
    input  issue_valid, iter_last, zero_rep, hold, offs, remaining, busy
  );

  modport slave (
    input  valid_in, is_rep_in, rep_num, opsize_in, df, stall_in, flush,
    output issue_valid, iter_last, zero_rep, hold, offs, remaining, busy
  );
endinterface

// File: rtl/kogeAdder.sv
// Kogge-Stone parallel-prefix adder, sum = a + b modulo 2^W.
module kogeAdder #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  localparam int unsigned LVL = $clog2(W);

  logic [W-1:0] gc, pc, gn, pn;

  // Prefix tree over generate/propagate pairs; gc ends up as the carry-out of each bit.
  always_comb begin
    gc = a & b;
    pc = a ^ b;
    gn = gc;
    pn = pc;
    for (int k = 0; k < int'(LVL); k++) begin
      for (int i = 0; i < int'(W); i++) begin
        if (i >= (1 << k)) begin
          gn[i] = gc[i] | (pc[i] & gc[i - (1 << k)]);
          pn[i] = pc[i] & pc[i - (1 << k)];
        end else begin
          gn[i] = gc[i];
          pn[i] = pc[i];
        end
      end
      gc = gn;
      pc = pn;
    end
    sum = (a ^ b) ^ {gc[W-2:0], 1'b0};
  end

endmodule

// File: rtl/rep_offs_acc.sv
// Byte-offset accumulator for REP iterations; wraps silently modulo 2^32.
module rep_offs_acc
  import rep_ctrl_pkg::*;
(
  input  logic  clk,
  input  logic  clr,
  input  logic  clear,
  input  logic  adv,
  input  data_t step,
  output data_t offs
);

  data_t sum;

  kogeAdder #(.W(DATA_W)) u_add (
    .a   (offs),
    .b   (step),
    .sum (sum)
  );

  // clear wins over advance so load, last issue and flush all restart at zero.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      offs <= '0;
    end else if (clear) begin
      offs <= '0;
    end else if (adv) begin
      offs <= sum;
    end
  end

endmodule

// File: rtl/rep_ctrl.sv
// REP-prefix sequencer: expands a REP instruction into per-element issues.
module rep_ctrl
  import rep_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  rep_ctrl_if.slave  bus
);

  state_t state, state_nx;
  data_t  cnt, cnt_nx;
  data_t  step, step_nx;
  data_t  offs;
  logic   issue_c, last_c, zero_c, hold_c;
  logic   offs_clear, offs_adv;

  // State, iteration counter and the step latched at RUN entry.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
      cnt   <= '0;
      step  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      step  <= step_nx;
    end
  end

  // Next-state and issue decode; flush overrides everything at the end.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    step_nx    = step;
    issue_c    = 1'b0;
    last_c     = 1'b0;
    zero_c     = 1'b0;
    hold_c     = 1'b0;
    offs_clear = 1'b0;
    offs_adv   = 1'b0;

    case (state)
      IDLE: begin
        if (bus.valid_in) begin
          if (!bus.is_rep_in) begin
            issue_c = !bus.stall_in;
            last_c  = issue_c;
          end else if (bus.rep_num == '0) begin
            zero_c = 1'b1;
          end else begin
            hold_c     = 1'b1;
            cnt_nx     = bus.rep_num;
            step_nx    = step_of(bus.opsize_in, bus.df);
            offs_clear = 1'b1;
            state_nx   = RUN;
          end
        end
      end
      RUN: begin
        issue_c = !bus.stall_in;
        last_c  = issue_c && (cnt == data_t'(1));
        hold_c  = !(issue_c && last_c);
        if (issue_c) begin
          if (last_c) begin
            state_nx   = IDLE;
            cnt_nx     = '0;
            offs_clear = 1'b1;
          end else begin
            cnt_nx   = cnt - data_t'(1);
            offs_adv = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase

    if (bus.flush) begin
      issue_c    = 1'b0;
      last_c     = 1'b0;
      zero_c     = 1'b0;
      hold_c     = 1'b0;
      state_nx   = IDLE;
      cnt_nx     = '0;
      offs_clear = 1'b1;
      offs_adv   = 1'b0;
    end
  end

  rep_offs_acc u_offs (
    .clk   (clk),
    .clr   (clr),
    .clear (offs_clear),
    .adv   (offs_adv),
    .step  (step),
    .offs  (offs)
  );

  assign bus.issue_valid = issue_c;
  assign bus.iter_last   = last_c;
  assign bus.zero_rep    = zero_c;
  assign bus.hold        = hold_c;
  assign bus.offs        = offs;
  assign bus.remaining   = (state == RUN) ? cnt : '0;
  assign bus.busy        = (state == RUN);

endmodule

// File: tb/tb_rep_ctrl.sv
// Directed self-checking bench for rep_ctrl with a reference model and issue scoreboard.
module tb_rep_ctrl;

  typedef struct packed {
    logic [31:0] offs;
    logic [31:0] rem;
    logic        last;
  } iss_t;

  logic clk;
  logic clr;
  int   checks;
  int   errors;
  string cur_test;

  iss_t        sb[$];
  logic [31:0] iss_offs[$];

  logic        m_run;
  logic [31:0] m_cnt, m_offs, m_step;

  rep_ctrl_if bus ();

  rep_ctrl dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s observed=%h expected=%h", cur_test, tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run  = 1'b0;
    m_cnt  = '0;
    m_offs = '0;
    m_step = '0;
  endtask

  // One clock cycle: drive at negedge, predict, check before the next posedge.
  task automatic cycle(input logic v, input logic r, input logic [31:0] n,
                       input logic [1:0] os, input logic d, input logic st, input logic fl);
    logic e_iss, e_last, e_zr, e_hold, n_run;
    logic [31:0] n_cnt, n_offs, n_step;
    iss_t got;
    @(negedge clk);
    bus.valid_in  = v;
    bus.is_rep_in = r;
    bus.rep_num   = n;
    bus.opsize_in = os;
    bus.df        = d;
    bus.stall_in  = st;
    bus.flush     = fl;
    e_iss = 0; e_last = 0; e_zr = 0; e_hold = 0;
    n_run = m_run; n_cnt = m_cnt; n_offs = m_offs; n_step = m_step;
    if (fl) begin
      n_run = 0; n_cnt = 0; n_offs = 0;
    end else if (!m_run) begin
      if (v && !r) begin
        e_iss = !st; e_last = e_iss;
      end else if (v && r && n == 0) begin
        e_zr = 1;
      end else if (v && r) begin
        e_hold = 1; n_run = 1; n_cnt = n; n_offs = 0;
        n_step = d ? (32'd0 - (32'd1 << os)) : (32'd1 << os);
      end
    end else begin
      e_iss  = !st;
      e_last = e_iss && (m_cnt == 1);
      e_hold = !(e_iss && e_last);
      if (e_iss) begin
        if (m_cnt == 1) begin
          n_run = 0; n_cnt = 0; n_offs = 0;
        end else begin
          n_cnt = m_cnt - 1; n_offs = m_offs + m_step;
        end
      end
    end
    if (e_iss) sb.push_back('{offs: m_offs, rem: (m_run ? m_cnt : 32'd0), last: e_last});
    #2;
    chk("issue_valid", 32'(bus.issue_valid), 32'(e_iss));
    chk("iter_last", 32'(bus.iter_last), 32'(e_last));
    chk("zero_rep", 32'(bus.zero_rep), 32'(e_zr));
    chk("hold", 32'(bus.hold), 32'(e_hold));
    chk("busy", 32'(bus.busy), 32'(m_run));
    chk("remaining", bus.remaining, m_run ? m_cnt : 32'd0);
    chk("offs", bus.offs, m_offs);
    if (bus.issue_valid === 1'b1) begin
      iss_offs.push_back(bus.offs);
      if (sb.size() == 0) begin
        chk("sb_unexpected_issue", 32'd1, 32'd0);
      end else begin
        got = sb.pop_front();
        chk("sb_offs", bus.offs, got.offs);
        chk("sb_remaining", bus.remaining, got.rem);
        chk("sb_last", 32'(bus.iter_last), 32'(got.last));
      end
    end
    m_run = n_run; m_cnt = n_cnt; m_offs = n_offs; m_step = n_step;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 32'd0, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run(input logic st);
    // Size/direction deliberately scrambled: must be ignored while running.
    cycle(1'b0, 1'b0, 32'd0, 2'($urandom_range(3)), 1'($urandom_range(1)), st, 1'b0);
  endtask

  task automatic end_test();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    sb.delete();
    iss_offs.delete();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cur_test = "reset";
    model_reset();
    clr = 1'b1;
    bus.valid_in = 0; bus.is_rep_in = 0; bus.rep_num = 0; bus.opsize_in = 0;
    bus.df = 0; bus.stall_in = 0; bus.flush = 0;
    #12;
    chk("busy", 32'(bus.busy), 32'd0);
    chk("remaining", bus.remaining, 32'd0);
    chk("offs", bus.offs, 32'd0);
    chk("issue_valid", 32'(bus.issue_valid), 32'd0);
    chk("hold", 32'(bus.hold), 32'd0);
    @(negedge clk);
    clr = 1'b0;

    cur_test = "non_rep";
    cycle(1, 0, 32'd0, 2'b10, 0, 0, 0);
    cycle(1, 0, 32'd0, 2'b10, 0, 1, 0);
    idle();
    chk("issues", 32'(iss_offs.size()), 32'd1);
    end_test();

    cur_test = "rep3_inc";
    cycle(1, 1, 32'd3, 2'b10, 0, 0, 0);
    repeat (3) run(0);
    idle();
    chk("issues", 32'(iss_offs.size()), 32'd3);
    if (iss_offs.size() == 3) begin
      chk("offs_1", iss_offs[0], 32'd0);
      chk("offs_2", iss_offs[1], 32'd4);
      chk("offs_3", iss_offs[2], 32'd8);
    end
    end_test();

    cur_test = "rep2_dec_stall";
    cycle(1, 1, 32'd2, 2'b00, 1, 0, 0);
    run(0);
    run(1);
    run(1);
    run(0);
    idle();
    chk("issues", 32'(iss_offs.size()), 32'd2);
    if (iss_offs.size() == 2) begin
      chk("offs_1", iss_offs[0], 32'h0000_0000);
      chk("offs_2", iss_offs[1], 32'hFFFF_FFFF);
    end
    end_test();

    cur_test = "rep_zero";
    cycle(1, 1, 32'd0, 2'b01, 0, 0, 0);
    idle();
    end_test();

    cur_test = "rep5_flush";
    cycle(1, 1, 32'd5, 2'b01, 0, 0, 0);
    run(0);
    cycle(0, 0, 32'd0, 2'b01, 0, 0, 1);
    idle();
    chk("remaining_after", bus.remaining, 32'd0);
    chk("offs_after", bus.offs, 32'd0);
    idle();
    chk("issues", 32'(iss_offs.size()), 32'd1);
    end_test();

    cur_test = "rep1_load_under_stall";
    cycle(1, 1, 32'd1, 2'b11, 0, 1, 0);
    run(1);
    run(0);
    cycle(1, 0, 32'd0, 2'b00, 0, 0, 0);
    idle();
    chk("issues", 32'(iss_offs.size()), 32'd2);
    end_test();

    cur_test = "rep_max_wrap";
    cycle(1, 1, 32'hFFFF_FFFF, 2'b11, 1, 0, 0);
    repeat (3) run(0);
    chk("issues", 32'(iss_offs.size()), 32'd3);
    if (iss_offs.size() == 3) begin
      chk("offs_3", iss_offs[2], 32'hFFFF_FFF0);
    end
    cycle(1, 1, 32'd7, 2'b00, 0, 0, 1);
    idle();
    end_test();

    cur_test = "clr_mid_run";
    cycle(1, 1, 32'd4, 2'b00, 0, 0, 0);
    run(0);
    @(negedge clk);
    #3;
    clr = 1'b1;
    #1;
    chk("busy_async", 32'(bus.busy), 32'd0);
    chk("remaining_async", bus.remaining, 32'd0);
    chk("offs_async", bus.offs, 32'd0);
    model_reset();
    @(negedge clk);
    clr = 1'b0;
    repeat (3) idle();
    chk("issues", 32'(iss_offs.size()), 32'd1);
    end_test();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
